lc3_bus_monitor: RTL and testbench

//  Passive transaction recorder on the LC-3 core's memory bus, downstream of the DUT memory port.
//  - Every qualified bus cycle becomes one tagged record: FETCH, LOAD or STORE.
//  - Records are buffered in a FIFO and handed to the scoreboard over a valid/ready interface.
//  - Dropped records and protocol errors are counted and flagged, so the checker never silently loses history.

---
 rtl/lc3_mon_pkg.sv | 20 ++
 rtl/mon_fifo.sv | 53 +++++
 rtl/lc3_bus_monitor.sv | 103 ++++++++++
 tb/tb_lc3_bus_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mon_pkg.sv
// rtl/lc3_mon_pkg.sv - shared record types for the LC-3 memory bus monitor
package lc3_mon_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } txn_kind_t;

  // Default-width record as seen by the scoreboard side
  typedef struct packed {
    txn_kind_t        kind;
    logic [15:0]      addr;
    logic [15:0]      data;
    logic [SEQ_W-1:0] seq;
  } txn_t;

endpackage

// File: rtl/mon_fifo.sv
// rtl/mon_fifo.sv - record FIFO: storage, wrapping pointers, occupancy
module mon_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (occupancy != '0);
  assign full    = (occupancy == FULL_OCC);
  assign do_pop  = pop && valid;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/lc3_bus_monitor.sv
// rtl/lc3_bus_monitor.sv - passive LC-3 memory bus recorder with FIFO and drop/error stats
module lc3_bus_monitor
  import lc3_mon_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      dataToMemory,
  input  logic [DATA_W-1:0]      dataFromMemory,
  input  logic                   writeEnable,
  input  logic                   memRead,
  input  logic                   fetch,
  input  logic                   clr_stats,
  output logic                   txn_valid,
  input  logic                   txn_ready,
  output logic [1:0]             txn_kind,
  output logic [ADDR_W-1:0]      txn_addr,
  output logic [DATA_W-1:0]      txn_data,
  output logic [SEQ_W-1:0]       txn_seq,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            drop_count,
  output logic                   overflow,
  output logic                   proto_err
);

  typedef struct packed {
    txn_kind_t         kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } rec_t;

  rec_t             rec;
  rec_t             head;
  logic             qualified;
  logic             strobe_err;
  logic             full;
  logic             drop;
  logic [SEQ_W-1:0] seq;

  // Store outranks fetch, fetch outranks load
  always_comb begin
    rec.kind   = LOAD;
    rec.addr   = address;
    rec.data   = dataFromMemory;
    rec.seq    = seq;
    if (writeEnable) begin
      rec.kind = STORE;
      rec.data = dataToMemory;
    end else if (fetch) begin
      rec.kind = FETCH;
    end
  end

  assign qualified  = writeEnable || fetch || memRead;
  assign strobe_err = writeEnable && (fetch || memRead);
  assign drop       = qualified && full && !(txn_valid && txn_ready);

  mon_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (qualified),
    .push_data (rec),
    .pop       (txn_ready),
    .head      (head),
    .valid     (txn_valid),
    .full      (full),
    .occupancy (occupancy)
  );

  assign txn_kind = head.kind;
  assign txn_addr = head.addr;
  assign txn_data = head.data;
  assign txn_seq  = head.seq;

  // Dropped records still burn a sequence number so the consumer sees the gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq        <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (qualified) seq <= seq + 1'b1;
      if (drop) begin
        if (clr_stats)                  drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (clr_stats) begin
        drop_count <= '0;
      end
      overflow  <= drop || (overflow && !clr_stats);
      proto_err <= strobe_err || (proto_err && !clr_stats);
    end
  end

endmodule

// File: tb/tb_lc3_bus_monitor.sv
// tb/tb_lc3_bus_monitor.sv - directed self-checking bench for lc3_bus_monitor
module tb_lc3_bus_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] dataToMemory;
  logic [15:0] dataFromMemory;
  logic        writeEnable;
  logic        memRead;
  logic        fetch;
  logic        clr_stats;
  logic        txn_valid;
  logic        txn_ready;
  logic [1:0]  txn_kind;
  logic [15:0] txn_addr;
  logic [15:0] txn_data;
  logic [15:0] txn_seq;
  logic [4:0]  occupancy;
  logic [15:0] drop_count;
  logic        overflow;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;
  int seq_bad  = 0;

  always #5 clk = ~clk;

  lc3_bus_monitor #(.DEPTH(16), .ADDR_W(16), .DATA_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .dataToMemory   (dataToMemory),
    .dataFromMemory (dataFromMemory),
    .writeEnable    (writeEnable),
    .memRead        (memRead),
    .fetch          (fetch),
    .clr_stats      (clr_stats),
    .txn_valid      (txn_valid),
    .txn_ready      (txn_ready),
    .txn_kind       (txn_kind),
    .txn_addr       (txn_addr),
    .txn_data       (txn_data),
    .txn_seq        (txn_seq),
    .occupancy      (occupancy),
    .drop_count     (drop_count),
    .overflow       (overflow),
    .proto_err      (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEnable = 1'b0;
    memRead     = 1'b0;
    fetch       = 1'b0;
    clr_stats   = 1'b0;
  endtask

  task automatic bus(input logic we, input logic rd, input logic fe,
                     input logic [15:0] a, input logic [15:0] dtm, input logic [15:0] dfm);
    writeEnable    = we;
    memRead        = rd;
    fetch          = fe;
    address        = a;
    dataToMemory   = dtm;
    dataFromMemory = dfm;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2;
    check("rst_valid", {31'd0, txn_valid}, 32'd0);
    check("rst_occ", {27'd0, occupancy}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    txn_ready = 1'b1;
    address = '0; dataToMemory = '0; dataFromMemory = '0;
    idle();

    // Strobes toggling under reset must not create records
    for (int i = 0; i < 4; i++) begin
      bus(i[0], i[1], ~i[0], 16'h1000 + 16'(i), 16'h5555, 16'hAAAA);
      tick();
      check("reset_valid", {31'd0, txn_valid}, 32'd0);
      check("reset_occ", {27'd0, occupancy}, 32'd0);
      check("reset_drops", {16'd0, drop_count}, 32'd0);
    end
    idle();
    reset = 1'b1;
    tick();

    // Mixed traffic with consumer always ready
    bus(0, 0, 1, 16'h3000, 16'h0000, 16'h1234);
    tick();
    check("fetch_valid", {31'd0, txn_valid}, 32'd1);
    check("fetch_kind", {30'd0, txn_kind}, 32'd0);
    check("fetch_addr", {16'd0, txn_addr}, 32'h3000);
    check("fetch_data", {16'd0, txn_data}, 32'h1234);
    check("fetch_seq", {16'd0, txn_seq}, 32'd0);
    bus(0, 1, 0, 16'h4000, 16'h0000, 16'hBEEF);
    tick();
    check("load_kind", {30'd0, txn_kind}, 32'd1);
    check("load_addr", {16'd0, txn_addr}, 32'h4000);
    check("load_data", {16'd0, txn_data}, 32'hBEEF);
    check("load_seq", {16'd0, txn_seq}, 32'd1);
    bus(1, 0, 0, 16'h4001, 16'h00AA, 16'h7777);
    tick();
    check("store_kind", {30'd0, txn_kind}, 32'd2);
    check("store_addr", {16'd0, txn_addr}, 32'h4001);
    check("store_data", {16'd0, txn_data}, 32'h00AA);
    check("store_seq", {16'd0, txn_seq}, 32'd2);
    check("store_occ", {27'd0, occupancy}, 32'd1);
    idle();
    tick();
    check("drained_valid", {31'd0, txn_valid}, 32'd0);

    // Store plus fetch in one cycle: one STORE record, error flagged
    txn_ready = 1'b0;
    bus(1, 0, 1, 16'h5000, 16'hCAFE, 16'h1111);
    tick();
    idle();
    check("err_kind", {30'd0, txn_kind}, 32'd2);
    check("err_data", {16'd0, txn_data}, 32'hCAFE);
    check("err_seq", {16'd0, txn_seq}, 32'd3);
    check("err_occ", {27'd0, occupancy}, 32'd1);
    check("err_flag", {31'd0, proto_err}, 32'd1);
    tick();
    check("err_hold_data", {16'd0, txn_data}, 32'hCAFE);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("err_cleared", {31'd0, proto_err}, 32'd0);
    check("clr_keeps_fifo", {27'd0, occupancy}, 32'd1);
    pulse_reset();
    tick();
    check("post_reset_valid", {31'd0, txn_valid}, 32'd0);

    // Backpressure: 18 fetches into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
      bus(0, 0, 1, 16'(i), 16'h0000, 16'h2000 + 16'(i));
      tick();
    end
    idle();
    check("ovf_occ", {27'd0, occupancy}, 32'd16);
    check("ovf_drops", {16'd0, drop_count}, 32'd2);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_head_seq", {16'd0, txn_seq}, 32'd0);

    // Full + push + pop on the same edge
    txn_ready = 1'b1;
    bus(0, 0, 1, 16'h0018, 16'h0000, 16'h2018);
    tick();
    idle();
    check("fpp_occ", {27'd0, occupancy}, 32'd16);
    check("fpp_drops", {16'd0, drop_count}, 32'd2);
    for (int i = 1; i <= 16; i++) begin
      logic [15:0] exp_seq;
      exp_seq = (i == 16) ? 16'd18 : 16'(i);
      check("drain_seq", {16'd0, txn_seq}, {16'd0, exp_seq});
      tick();
    end
    check("drain_empty", {31'd0, txn_valid}, 32'd0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_drops", {16'd0, drop_count}, 32'd0);
    check("clr_ovf", {31'd0, overflow}, 32'd0);

    // Sequence wrap across 16'hFFFF
    pulse_reset();
    for (int i = 0; i < 65538; i++) begin
      bus(0, 0, 1, i[15:0], 16'h0000, 16'h0000);
      tick();
      if (!txn_valid || txn_seq !== i[15:0]) seq_bad++;
      if (i == 65535) check("seq_ffff", {16'd0, txn_seq}, 32'h0000FFFF);
      if (i == 65536) check("seq_wrap", {16'd0, txn_seq}, 32'd0);
    end
    idle();
    check("seq_gaps", seq_bad, 32'd0);
    check("wrap_drops", {16'd0, drop_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
